// File: rtl/reset_sequencer.sv
// Board reset sequencer: synchronises button and lock flags, debounces the button,
// holds reset until all locks are stable, then releases domain resets in staggered order.
// Optional lock-loss event counter is built when LOCK_LOSS_COUNT_EN is defined.
module reset_sequencer #(
   parameter int NUM_LOCKS     = 2,
   parameter int SYNC_STAGES   = 3,
   parameter int DEBOUNCE_BITS = 20,
   parameter int HOLD_CYCLES   = 16,
   parameter int NUM_DOMAINS   = 2,
   parameter int STAGGER       = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   btn_in,
   input  logic [NUM_LOCKS-1:0]   lock_in,
   input  logic                   sw_rst_req,
   output logic [NUM_DOMAINS-1:0] rst_out,
   output logic                   ready,
   output logic [1:0]             state_o,
   output logic [7:0]             loss_count
);

   localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
   localparam logic [1:0] ST_HOLD      = 2'd1;
   localparam logic [1:0] ST_RELEASE   = 2'd2;
   localparam logic [1:0] ST_RUN       = 2'd3;

   localparam int REL_LAST = (NUM_DOMAINS - 1) * STAGGER;
   localparam int CNT_MAX  = (HOLD_CYCLES > REL_LAST + 1) ? HOLD_CYCLES : REL_LAST + 1;
   localparam int CW       = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] REL_END   = CW'(REL_LAST);
   // Compare against max-1 so the update lands on the edge the count would reach max.
   localparam logic [DEBOUNCE_BITS-1:0] DB_LAST = DEBOUNCE_BITS'((2 ** DEBOUNCE_BITS) - 2);

   logic [SYNC_STAGES-1:0]                btn_sync_q;
   logic [SYNC_STAGES-1:0][NUM_LOCKS-1:0] lock_sync_q;
   logic                                  btn_s;
   logic                                  all_lock_s;
   logic                                  req_s;

   logic [DEBOUNCE_BITS-1:0] db_cnt_q, db_cnt_d;
   logic                     btn_stable_q, btn_stable_d;
   logic                     btn_req_q, btn_req_d;

   logic [1:0]             state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [NUM_DOMAINS-1:0] rst_q, rst_d;
   logic                   ready_q, ready_d;

   assign btn_s      = btn_sync_q[SYNC_STAGES-1];
   assign all_lock_s = &lock_sync_q[SYNC_STAGES-1];
   assign req_s      = btn_req_q | sw_rst_req;

   // Button debounce: the stable level follows btn_s only after a full run of disagreement.
   always_comb begin
      db_cnt_d     = db_cnt_q;
      btn_stable_d = btn_stable_q;
      btn_req_d    = 1'b0;
      if (btn_s == btn_stable_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         db_cnt_d     = '0;
         btn_stable_d = btn_s;
         btn_req_d    = btn_s;
      end else begin
         db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   // Sequencer next-state: lock loss outranks requests, which outrank counter expiry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rst_d   = rst_q;
      ready_d = ready_q;
      case (state_q)
         ST_WAIT_LOCK: begin
            rst_d   = '1;
            ready_d = 1'b0;
            if (all_lock_s) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end else begin
               state_d = ST_WAIT_LOCK;
            end
         end
         ST_HOLD: begin
            rst_d   = '1;
            ready_d = 1'b0;
            if (!all_lock_s) begin
               state_d = ST_WAIT_LOCK;
            end else if (req_s) begin
               cnt_d = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = ST_RELEASE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RELEASE: begin
            if (!all_lock_s || req_s) begin
               state_d = ST_WAIT_LOCK;
               rst_d   = '1;
               ready_d = 1'b0;
            end else begin
               for (int i = 0; i < NUM_DOMAINS; i++) begin
                  if (cnt_q == CW'(i * STAGGER)) begin
                     rst_d[i] = 1'b0;
                  end else begin
                     rst_d[i] = rst_q[i];
                  end
               end
               if (cnt_q == REL_END) begin
                  state_d = ST_RUN;
                  ready_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (!all_lock_s || req_s) begin
               state_d = ST_WAIT_LOCK;
               rst_d   = '1;
               ready_d = 1'b0;
            end else begin
               state_d = ST_RUN;
               rst_d   = '0;
               ready_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
         end
      endcase
   end

   // Synchronisers, debounce state and sequencer registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         btn_sync_q   <= '0;
         lock_sync_q  <= '0;
         db_cnt_q     <= '0;
         btn_stable_q <= 1'b0;
         btn_req_q    <= 1'b0;
         state_q      <= ST_WAIT_LOCK;
         cnt_q        <= '0;
         rst_q        <= '1;
         ready_q      <= 1'b0;
      end else begin
         btn_sync_q   <= {btn_sync_q[SYNC_STAGES-2:0], btn_in};
         lock_sync_q  <= {lock_sync_q[SYNC_STAGES-2:0], lock_in};
         db_cnt_q     <= db_cnt_d;
         btn_stable_q <= btn_stable_d;
         btn_req_q    <= btn_req_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rst_q        <= rst_d;
         ready_q      <= ready_d;
      end
   end

   assign rst_out = rst_q;
   assign ready   = ready_q;
   assign state_o = state_q;

`ifdef LOCK_LOSS_COUNT_EN
   logic       lost_s;
   logic [7:0] loss_q, loss_d;

   // Any armed state dropping back on lock loss is one event, even with a coincident request.
   assign lost_s = (state_q != ST_WAIT_LOCK) && !all_lock_s;

   // Saturating loss counter next value.
   always_comb begin
      if (lost_s && (loss_q != 8'hFF)) begin
         loss_d = loss_q + 8'd1;
      end else begin
         loss_d = loss_q;
      end
   end

   // Loss counter register, cleared only by reset_n.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         loss_q <= 8'h00;
      end else begin
         loss_q <= loss_d;
      end
   end

   assign loss_count = loss_q;
`else
   assign loss_count = 8'h00;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timeline model of the release sequence plus directed scenarios.
module tb_reset_sequencer;

   localparam int NL  = 2;
   localparam int SS  = 3;
   localparam int DB  = 4;
   localparam int HC  = 16;
   localparam int ND  = 2;
   localparam int STG = 8;
   // Edges after arming at which RUN is reached.
   localparam int RUN_AT = HC + 1 + (ND - 1) * STG;
`ifdef LOCK_LOSS_COUNT_EN
   localparam int LE    = 1;
   localparam int NDROP = 260;
`else
   localparam int LE    = 0;
   localparam int NDROP = 3;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          btn_in = 1'b0;
   logic          sw_rst_req = 1'b0;
   logic [NL-1:0] lock_in = '0;
   logic [ND-1:0] rst_out;
   logic          ready;
   logic [1:0]    state_o;
   logic [7:0]    loss_count;

   int total = 0;
   int bad   = 0;

   reset_sequencer #(
      .NUM_LOCKS(NL), .SYNC_STAGES(SS), .DEBOUNCE_BITS(DB),
      .HOLD_CYCLES(HC), .NUM_DOMAINS(ND), .STAGGER(STG)
   ) dut (
      .clk(clk), .reset_n(reset_n), .btn_in(btn_in), .lock_in(lock_in),
      .sw_rst_req(sw_rst_req), .rst_out(rst_out), .ready(ready),
      .state_o(state_o), .loss_count(loss_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: the sequence is a pure function of edges elapsed since the last (re)arm.
   int            edge_n  = 0;
   bit            m_valid = 1'b0;
   bit            m_armed = 1'b0;
   int            m_start = 0;
   int            m_loss  = 0;
   int            m_run   = 0;
   logic          m_stable = 1'b0;
   logic          m_pulse  = 1'b0;
   logic [NL-1:0] lh [SS];
   logic          bh [SS];

   function automatic int phase_of(input int e);
      if (e < HC) return 1;
      else if (e < RUN_AT) return 2;
      else return 3;
   endfunction

   function automatic logic [ND-1:0] rst_of(input int e);
      logic [ND-1:0] r;
      for (int i = 0; i < ND; i++) r[i] = (e < HC + 1 + i * STG);
      return r;
   endfunction

   initial begin
      logic lk, bs, rq;
      forever begin
         @(posedge clk);
         edge_n++;
         if (!reset_n) begin
            m_valid = 1'b1; m_armed = 1'b0; m_loss = 0; m_run = 0;
            m_stable = 1'b0; m_pulse = 1'b0;
            for (int k = 0; k < SS; k++) begin lh[k] = '0; bh[k] = 1'b0; end
         end else begin
            lk = &lh[SS-1];
            bs = bh[SS-1];
            rq = sw_rst_req | m_pulse;
            m_pulse = 1'b0;
            if (bs == m_stable) m_run = 0;
            else begin
               m_run++;
               if (m_run == (2 ** DB) - 1) begin
                  m_stable = bs; m_run = 0; m_pulse = bs;
               end
            end
            if (m_armed) begin
               if (!lk) begin
                  m_armed = 1'b0;
                  if (m_loss < 255) m_loss++;
               end else if (rq) begin
                  if (phase_of(edge_n - 1 - m_start) == 1) m_start = edge_n;
                  else m_armed = 1'b0;
               end
            end else if (lk) begin
               m_armed = 1'b1; m_start = edge_n;
            end
            for (int k = SS - 1; k > 0; k--) begin lh[k] = lh[k-1]; bh[k] = bh[k-1]; end
            lh[0] = lock_in;
            bh[0] = btn_in;
         end
      end
   end

   // Every-cycle compare of DUT outputs against the model.
   initial begin
      int es;
      logic [ND-1:0] er;
      forever begin
         @(negedge clk);
         if (m_valid) begin
            if (m_armed) begin
               es = phase_of(edge_n - m_start);
               er = rst_of(edge_n - m_start);
            end else begin
               es = 0;
               er = '1;
            end
            chk("m_state", state_o, es);
            chk("m_rst_out", rst_out, er);
            chk("m_ready", ready, es == 3);
            chk("m_loss", loss_count, LE * m_loss);
         end
      end
   end

   // Directed scenarios with hand-computed edge expectations.
   initial begin
      // Power-up
      step(4);
      reset_n = 1'b1;
      step(1);
      chk("pwr_state", state_o, 2'd0);
      chk("pwr_rst", rst_out, 2'b11);
      chk("pwr_ready", ready, 1'b0);
      chk("pwr_loss", loss_count, 8'h00);
      step(10);
      chk("pwr_idle_state", state_o, 2'd0);
      chk("pwr_idle_rst", rst_out, 2'b11);

      // Lock up
      lock_in = 2'b11;
      step(3);  chk("lk_e3_state", state_o, 2'd0);
      step(1);  chk("lk_e4_hold", state_o, 2'd1);
      step(15); chk("lk_e19_hold", state_o, 2'd1);
      step(1);  chk("lk_e20_rel", state_o, 2'd2);
                chk("lk_e20_rst", rst_out, 2'b11);
      step(1);  chk("lk_e21_rst", rst_out, 2'b10);
      step(7);  chk("lk_e28_rst", rst_out, 2'b10);
                chk("lk_e28_ready", ready, 1'b0);
      step(1);  chk("lk_e29_rst", rst_out, 2'b00);
                chk("lk_e29_ready", ready, 1'b1);
                chk("lk_e29_state", state_o, 2'd3);

      // Drop locks from RUN, then glitch during the hold
      lock_in = 2'b00;
      step(3);  chk("drop_e3_state", state_o, 2'd3);
      step(1);  chk("drop_e4_state", state_o, 2'd0);
                chk("drop_e4_rst", rst_out, 2'b11);
      lock_in = 2'b11;
      step(14); chk("gl_e14_hold", state_o, 2'd1);
      lock_in = 2'b01;
      step(1);
      lock_in = 2'b11;
      step(2);  chk("gl_e17_hold", state_o, 2'd1);
      step(1);  chk("gl_e18_wait", state_o, 2'd0);
                chk("gl_e18_rst", rst_out, 2'b11);
      step(1);  chk("gl_e19_hold", state_o, 2'd1);
      step(15); chk("gl_e34_hold", state_o, 2'd1);
      step(1);  chk("gl_e35_rel", state_o, 2'd2);
      step(9);  chk("gl_e44_run", state_o, 2'd3);
      chk("gl_loss", loss_count, 2 * LE);

      // Bouncing button, then held: exactly one request
      for (int p = 0; p < 10; p++) begin
         btn_in = (p % 2 == 0);
         step(3);
      end
      chk("btn_bounce_run", state_o, 2'd3);
      btn_in = 1'b1;
      step(18); chk("btn_e18_run", state_o, 2'd3);
      step(1);  chk("btn_e19_wait", state_o, 2'd0);
                chk("btn_e19_rst", rst_out, 2'b11);
      step(25); chk("btn_e44_rel", state_o, 2'd2);
      step(1);  chk("btn_e45_run", state_o, 2'd3);
      btn_in = 1'b0;
      step(40); chk("btn_rel_run", state_o, 2'd3);
                chk("btn_rel_rst", rst_out, 2'b00);

      // Software request from RUN, then a request that restarts the hold
      sw_rst_req = 1'b1; step(1); sw_rst_req = 1'b0;
      chk("sw_e1_wait", state_o, 2'd0);
      step(1);  chk("sw_e2_hold", state_o, 2'd1);
      step(5);
      sw_rst_req = 1'b1; step(1); sw_rst_req = 1'b0;
      step(15); chk("sw_e23_hold", state_o, 2'd1);
      step(1);  chk("sw_e24_rel", state_o, 2'd2);
      step(9);  chk("sw_e33_run", state_o, 2'd3);
      chk("sw_loss", loss_count, 2 * LE);

      // Coincident request and lock loss after a fresh reset
      reset_n = 1'b0; step(2); reset_n = 1'b1;
      step(1);  chk("co_rst_loss", loss_count, 8'h00);
      step(28); chk("co_run", state_o, 2'd3);
      lock_in = 2'b10;
      step(3);
      sw_rst_req = 1'b1; step(1); sw_rst_req = 1'b0;
      chk("co_state", state_o, 2'd0);
      chk("co_rst", rst_out, 2'b11);
      chk("co_loss", loss_count, LE);
      step(5);
      chk("co_loss_hold", loss_count, LE);

      // Repeated lock drops from RUN
      for (int n = 0; n < NDROP; n++) begin
         lock_in = 2'b11; step(29);
         lock_in = 2'b00; step(4);
      end
      chk("sat_loss", loss_count, LE * 255);
      reset_n = 1'b0; step(1); reset_n = 1'b1;
      chk("sat_clr_loss", loss_count, 8'h00);
      chk("sat_clr_state", state_o, 2'd0);

      step(1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
